mem_arb: RTL and testbench

Request arbiter and in-order request buffer between the L1 instruction/data caches and the memory interface. Accepts one request per cycle from either cache, tags it with a rolling transaction ID, queues it in an N_LINES-deep FIFO, and presents the oldest entry to memory. Memory responses pass back to the caches tagged with their ID.

---
 rtl/mem_arb_if.sv | 44 ++++
 rtl/mem_arb.sv | 102 ++++++++++
 tb/tb_mem_arb.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// Cache-side and memory-side signal bundle for mem_arb.
// slave = arbiter view, master = requester/memory model view.
interface mem_arb_if #(
    parameter int PA_WIDTH   = 8,
    parameter int LINE_WIDTH = 16,
    parameter int ID_WIDTH   = 3
);
    logic                  i_instr_enable;
    logic [PA_WIDTH-1:0]   i_instr_addr;
    logic                  i_data_enable;
    logic [PA_WIDTH-1:0]   i_data_addr;
    logic [LINE_WIDTH-1:0] i_data;
    logic                  i_data_write;
    logic                  i_ack;
    logic                  o_enable;
    logic [ID_WIDTH-1:0]   o_id_request;
    logic [ID_WIDTH-1:0]   o_id_response;
    logic [LINE_WIDTH-1:0] o_data;
    logic                  o_stall;
    logic                  i_mem_enable;
    logic [ID_WIDTH-1:0]   i_mem_id;
    logic [LINE_WIDTH-1:0] i_mem_data;
    logic                  i_mem_ack;
    logic                  o_mem_ack;
    logic [PA_WIDTH-1:0]   o_mem_addr;
    logic [LINE_WIDTH-1:0] o_mem_data;
    logic                  o_mem_enable;
    logic                  o_mem_write;
    logic [ID_WIDTH-1:0]   o_mem_id;

    modport slave (
        input  i_instr_enable, i_instr_addr, i_data_enable, i_data_addr, i_data,
               i_data_write, i_ack, i_mem_enable, i_mem_id, i_mem_data, i_mem_ack,
        output o_enable, o_id_request, o_id_response, o_data, o_stall, o_mem_ack,
               o_mem_addr, o_mem_data, o_mem_enable, o_mem_write, o_mem_id
    );

    modport master (
        output i_instr_enable, i_instr_addr, i_data_enable, i_data_addr, i_data,
               i_data_write, i_ack, i_mem_enable, i_mem_id, i_mem_data, i_mem_ack,
        input  o_enable, o_id_request, o_id_response, o_data, o_stall, o_mem_ack,
               o_mem_addr, o_mem_data, o_mem_enable, o_mem_write, o_mem_id
    );
endinterface

// File: rtl/mem_arb.sv
// I/D cache request arbiter with an in-order, ID-tagged request FIFO to memory.
// Optional macro MEM_ARB_RESP_REG_EN registers the response path (1-cycle latency).
module mem_arb #(
    parameter int PA_WIDTH   = 8,
    parameter int LINE_WIDTH = 16,
    parameter int ID_WIDTH   = 3,
    parameter int N_LINES    = 2
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);
    localparam int PTR_W = (N_LINES > 1) ? $clog2(N_LINES) : 1;
    localparam logic [PTR_W-1:0] LAST_LINE = PTR_W'(N_LINES - 1);

    logic [N_LINES-1:0]    valid;
    logic [N_LINES-1:0]    write;
    logic [ID_WIDTH-1:0]   line_id   [N_LINES];
    logic [PA_WIDTH-1:0]   line_addr [N_LINES];
    logic [LINE_WIDTH-1:0] line_data [N_LINES];
    logic [PTR_W-1:0]      oldest_line;
    logic [PTR_W-1:0]      newest_line;
    logic [ID_WIDTH-1:0]   id_counter;

    logic full;
    logic data_acc;
    logic instr_acc;
    logic enq;
    logic deq;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_LINE) ? '0 : p + 1'b1;
    endfunction

    // fullness is taken before any same-cycle dequeue, so a full buffer never enqueues
    always_comb begin
        full      = &valid;
        data_acc  = bus.i_data_enable && !full;
        instr_acc = bus.i_instr_enable && !bus.i_data_enable && !full;
        enq       = data_acc || instr_acc;
        deq       = bus.i_mem_ack && valid[oldest_line];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid       <= '0;
            write       <= '0;
            oldest_line <= '0;
            newest_line <= '0;
            id_counter  <= '0;
            for (int i = 0; i < N_LINES; i++) begin
                line_id[i]   <= '0;
                line_addr[i] <= '0;
                line_data[i] <= '0;
            end
        end else begin
            if (deq) begin
                valid[oldest_line] <= 1'b0;
                oldest_line        <= wrap_inc(oldest_line);
            end
            if (enq) begin
                valid[newest_line]     <= 1'b1;
                write[newest_line]     <= data_acc && bus.i_data_write;
                line_id[newest_line]   <= id_counter;
                line_addr[newest_line] <= data_acc ? bus.i_data_addr : bus.i_instr_addr;
                line_data[newest_line] <= data_acc ? bus.i_data : '0;
                newest_line            <= wrap_inc(newest_line);
                id_counter             <= id_counter + 1'b1;
            end
        end
    end

    assign bus.o_id_request = id_counter;
    assign bus.o_stall      = (full && (bus.i_instr_enable || bus.i_data_enable)) ||
                              (bus.i_instr_enable && bus.i_data_enable && !full);
    assign bus.o_mem_enable = valid[oldest_line];
    assign bus.o_mem_write  = write[oldest_line];
    assign bus.o_mem_addr   = line_addr[oldest_line];
    assign bus.o_mem_data   = line_data[oldest_line];
    assign bus.o_mem_id     = line_id[oldest_line];

`ifdef MEM_ARB_RESP_REG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.o_enable      <= 1'b0;
            bus.o_id_response <= '0;
            bus.o_data        <= '0;
            bus.o_mem_ack     <= 1'b0;
        end else begin
            bus.o_enable      <= bus.i_mem_enable;
            bus.o_id_response <= bus.i_mem_id;
            bus.o_data        <= bus.i_mem_data;
            bus.o_mem_ack     <= bus.i_ack;
        end
    end
`else
    assign bus.o_enable      = bus.i_mem_enable;
    assign bus.o_id_response = bus.i_mem_id;
    assign bus.o_data        = bus.i_mem_data;
    assign bus.o_mem_ack     = bus.i_ack;
`endif
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: a request scoreboard predicts the oldest entry on the memory side.
module tb_mem_arb;
    localparam int NL = 2;

    logic clk;
    logic rst;

    mem_arb_if #(.PA_WIDTH(8), .LINE_WIDTH(16), .ID_WIDTH(3)) bus ();

    mem_arb #(.PA_WIDTH(8), .LINE_WIDTH(16), .ID_WIDTH(3), .N_LINES(NL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
        logic        write;
        logic [2:0]  id;
    } req_t;

    req_t       sb[$];
    logic [2:0] exp_id;
    int         n_checks;
    int         n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one clock of stimulus: drive, check against the model, advance the model, clock
    task automatic cycle(input logic ie, input logic [7:0] ia,
                         input logic de, input logic [7:0] da, input logic [15:0] dd,
                         input logic dw, input logic mack);
        logic full, acc_d, acc_i;
        req_t f;
        bus.i_instr_enable = ie;
        bus.i_instr_addr   = ia;
        bus.i_data_enable  = de;
        bus.i_data_addr    = da;
        bus.i_data         = dd;
        bus.i_data_write   = dw;
        bus.i_mem_ack      = mack;
        #1;
        full  = (sb.size() == NL);
        acc_d = de && !full;
        acc_i = ie && !de && !full;
        chk("stall", bus.o_stall, (full && (ie || de)) || (ie && de && !full));
        if (acc_d || acc_i) chk("id_request", bus.o_id_request, exp_id);
        chk("mem_enable", bus.o_mem_enable, sb.size() > 0);
        if (sb.size() > 0) begin
            chk("mem_addr",  bus.o_mem_addr,  sb[0].addr);
            chk("mem_data",  bus.o_mem_data,  sb[0].data);
            chk("mem_write", bus.o_mem_write, sb[0].write);
            chk("mem_id",    bus.o_mem_id,    sb[0].id);
            if (mack) f = sb.pop_front();
        end
        if (acc_d) sb.push_back('{addr: da, data: dd, write: dw, id: exp_id});
        if (acc_i) sb.push_back('{addr: ia, data: 16'h0, write: 1'b0, id: exp_id});
        if (acc_d || acc_i) exp_id = exp_id + 3'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic mack);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 16'h0, 1'b0, mack);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_id   = 3'd0;
        rst      = 1'b0;
        bus.i_instr_enable = 1'b0; bus.i_instr_addr = '0;
        bus.i_data_enable  = 1'b0; bus.i_data_addr  = '0;
        bus.i_data = '0; bus.i_data_write = 1'b0; bus.i_ack = 1'b0;
        bus.i_mem_enable = 1'b0; bus.i_mem_id = '0; bus.i_mem_data = '0; bus.i_mem_ack = 1'b0;
        #1;
        chk("rst_mem_enable", bus.o_mem_enable, 1'b0);
        chk("rst_mem_write",  bus.o_mem_write,  1'b0);
        chk("rst_mem_addr",   bus.o_mem_addr,   8'h00);
        chk("rst_mem_id",     bus.o_mem_id,     3'd0);
        chk("rst_stall_idle", bus.o_stall,      1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // fill: instr then data write
        cycle(1'b1, 8'h01, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 8'h02, 16'hAAAA, 1'b1, 1'b0);
        idle(1'b0);
        // full: request stalls, then ack frees a line while still stalled
        cycle(1'b0, 8'h00, 1'b1, 8'h03, 16'hBBBB, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 8'h03, 16'hBBBB, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 8'h03, 16'hBBBB, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        // contention: data wins, instruction stalled
        cycle(1'b1, 8'h04, 1'b1, 8'h04, 16'hCCCC, 1'b1, 1'b0);
        idle(1'b0);
        chk("queued_count", sb.size(), 2);

        // response path
        bus.i_mem_enable = 1'b1; bus.i_mem_id = 3'd5; bus.i_mem_data = 16'h1234; bus.i_ack = 1'b1;
        #1;
`ifdef MEM_ARB_RESP_REG_EN
        chk("resp_enable_pre", bus.o_enable, 1'b0);
        chk("resp_ack_pre",    bus.o_mem_ack, 1'b0);
        @(posedge clk);
        #1;
`endif
        chk("resp_enable", bus.o_enable,      1'b1);
        chk("resp_id",     bus.o_id_response, 3'd5);
        chk("resp_data",   bus.o_data,        16'h1234);
        chk("resp_ack",    bus.o_mem_ack,     1'b1);
        bus.i_mem_enable = 1'b0; bus.i_mem_id = 3'd0; bus.i_mem_data = 16'h0; bus.i_ack = 1'b0;
        #1;
`ifdef MEM_ARB_RESP_REG_EN
        @(posedge clk);
        #1;
`endif
        chk("resp_enable_off", bus.o_enable,  1'b0);
        chk("resp_ack_off",    bus.o_mem_ack, 1'b0);
        @(posedge clk);
        #1;

        // reset mid-operation with two entries queued
        rst = 1'b0;
        bus.i_instr_enable = 1'b1;
        bus.i_data_enable  = 1'b1;
        #1;
        chk("midrst_mem_enable", bus.o_mem_enable, 1'b0);
        chk("midrst_mem_write",  bus.o_mem_write,  1'b0);
        chk("midrst_mem_addr",   bus.o_mem_addr,   8'h00);
        chk("midrst_mem_data",   bus.o_mem_data,   16'h0000);
        chk("midrst_stall",      bus.o_stall,      1'b1);
        bus.i_instr_enable = 1'b0;
        bus.i_data_enable  = 1'b0;
        sb.delete();
        exp_id = 3'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // nine single requests, each acked: IDs 0..7 then 0
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 0)
                cycle(1'b1, 8'(8'h10 + i), 1'b0, 8'h00, 16'h0, 1'b0, 1'b0);
            else
                cycle(1'b0, 8'h00, 1'b1, 8'(8'h20 + i), 16'(16'h5000 + i), 1'b1, 1'b0);
            idle(1'b1);
        end
        chk("wrap_next_id", bus.o_id_request, 3'd1);

        // enqueue and dequeue in the same cycle, then ack on empty buffer
        cycle(1'b1, 8'h50, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 8'h51, 16'h7777, 1'b1, 1'b1);
        chk("enq_deq_count", sb.size(), 1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
